// File: rtl/universal_shift_register_if.sv
// Command/status bundle for universal_shift_register: a controller drives the
// master side and the register implements the slave side.
interface universal_shift_register_if #(
  parameter int unsigned N  = 8,
  parameter int unsigned AW = 4
);
  logic          tick;
  logic          start;
  logic [2:0]    mode;
  logic [AW-1:0] amt;
  logic [N-1:0]  data;
  logic          sin;
  logic [N-1:0]  q;
  logic          busy;
  logic          done;
  logic          sout;

  modport master (
    output tick, start, mode, amt, data, sin,
    input  q, busy, done, sout
  );

  modport slave (
    input  tick, start, mode, amt, data, sin,
    output q, busy, done, sout
  );
endinterface

// File: rtl/universal_shift_register.sv
// Multi-step universal shift register: one single-bit shift/rotate per tick
// under a start/busy/done handshake. Define USR_ROT_EN to build ROL/ROR.
module universal_shift_register #(
  parameter int unsigned N  = 8,
  parameter int unsigned AW = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  universal_shift_register_if.slave  bus
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHL   = 3'b001;
  localparam logic [2:0] MODE_SHR   = 3'b010;
  localparam logic [2:0] MODE_ASR   = 3'b011;
`ifdef USR_ROT_EN
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
`endif
  localparam logic [2:0] MODE_LOAD  = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_n;
  logic [N-1:0]  q, q_n;
  logic          busy, busy_n;
  logic          done, done_n;
  logic          sout, sout_n;
  logic [AW-1:0] cnt, cnt_n;
  logic [2:0]    op, op_n;

  logic [AW-1:0] amt_c;
  logic          step_mode_c;
  logic [N-1:0]  step_q_c;
  logic          step_out_c;

  assign bus.q    = q;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.sout = sout;

  // Oversized step counts saturate at a full-width shift.
  assign amt_c = (bus.amt > AW'(N)) ? AW'(N) : bus.amt;

  // Modes that run through the stepped datapath.
  always_comb begin
    step_mode_c = 1'b0;
    case (bus.mode)
      MODE_SHL, MODE_SHR, MODE_ASR: step_mode_c = 1'b1;
`ifdef USR_ROT_EN
      MODE_ROL, MODE_ROR:           step_mode_c = 1'b1;
`endif
      default:                      step_mode_c = 1'b0;
    endcase
  end

  // Single-bit step on the current register contents for the latched op.
  always_comb begin
    step_q_c   = q;
    step_out_c = 1'b0;
    case (op)
      MODE_SHL: begin
        step_q_c   = {q[N-2:0], bus.sin};
        step_out_c = q[N-1];
      end
      MODE_SHR: begin
        step_q_c   = {bus.sin, q[N-1:1]};
        step_out_c = q[0];
      end
      MODE_ASR: begin
        step_q_c   = {q[N-1], q[N-1:1]};
        step_out_c = q[0];
      end
`ifdef USR_ROT_EN
      MODE_ROL: begin
        step_q_c   = {q[N-2:0], q[N-1]};
        step_out_c = q[N-1];
      end
      MODE_ROR: begin
        step_q_c   = {q[0], q[N-1:1]};
        step_out_c = q[0];
      end
`endif
      default: begin
        step_q_c   = q;
        step_out_c = 1'b0;
      end
    endcase
  end

  // Next-state and register update logic.
  always_comb begin
    state_n = state;
    q_n     = q;
    busy_n  = busy;
    done_n  = 1'b0;
    sout_n  = sout;
    cnt_n   = cnt;
    op_n    = op;
    case (state)
      IDLE: begin
        if (bus.start) begin
          case (bus.mode)
            MODE_LOAD: begin
              q_n    = bus.data;
              done_n = 1'b1;
            end
            MODE_CLEAR: begin
              q_n    = '0;
              done_n = 1'b1;
            end
            default: begin
              if (step_mode_c && (amt_c != '0)) begin
                op_n    = bus.mode;
                cnt_n   = amt_c;
                busy_n  = 1'b1;
                state_n = RUN;
              end else begin
                done_n = 1'b1;
              end
            end
          endcase
        end
      end
      RUN: begin
        if (bus.tick) begin
          q_n    = step_q_c;
          sout_n = step_out_c;
          cnt_n  = cnt - AW'(1);
          if (cnt == AW'(1)) begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      q     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sout  <= 1'b0;
      cnt   <= '0;
      op    <= MODE_HOLD;
    end else begin
      state <= state_n;
      q     <= q_n;
      busy  <= busy_n;
      done  <= done_n;
      sout  <= sout_n;
      cnt   <= cnt_n;
      op    <= op_n;
    end
  end

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register; rotate expectations follow
// whether USR_ROT_EN is defined for the build.
module tb_universal_shift_register;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;
  int   n_done;

  universal_shift_register_if #(.N(8), .AW(4)) bus ();

  universal_shift_register #(.N(8), .AW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle past the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a one-cycle start with the given command.
  task automatic issue(input logic [2:0] m, input logic [3:0] a, input logic [7:0] d);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.amt   = a;
    bus.data  = d;
    cyc();
    bus.start = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    reset     = 1'b0;
    bus.tick  = 1'b0;
    bus.start = 1'b0;
    bus.mode  = 3'b000;
    bus.amt   = 4'd0;
    bus.data  = 8'h00;
    bus.sin   = 1'b0;

    // Reset and idle
    cyc();
    cyc();
    reset = 1'b1;
    check("rst_q", 32'(bus.q), 32'h00);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_sout", 32'(bus.sout), 32'h0);
    for (int i = 0; i < 4; i++) begin
      bus.tick = ~bus.tick;
      cyc();
    end
    bus.tick = 1'b0;
    check("idle_q", 32'(bus.q), 32'h00);
    check("idle_busy", 32'(bus.busy), 32'h0);
    check("idle_done", 32'(bus.done), 32'h0);

    // LOAD then SHL by 3 with sin=1
    issue(3'b110, 4'd0, 8'hA5);
    check("load_q", 32'(bus.q), 32'hA5);
    check("load_done", 32'(bus.done), 32'h1);
    check("load_busy", 32'(bus.busy), 32'h0);
    cyc();
    check("load_done_fall", 32'(bus.done), 32'h0);
    bus.sin  = 1'b1;
    bus.tick = 1'b1;
    issue(3'b001, 4'd3, 8'h00);
    check("shl_accept_busy", 32'(bus.busy), 32'h1);
    check("shl_accept_q", 32'(bus.q), 32'hA5);
    cyc();
    check("shl_q1", 32'(bus.q), 32'h4B);
    check("shl_sout1", 32'(bus.sout), 32'h1);
    check("shl_busy1", 32'(bus.busy), 32'h1);
    cyc();
    check("shl_q2", 32'(bus.q), 32'h97);
    check("shl_sout2", 32'(bus.sout), 32'h0);
    check("shl_done2", 32'(bus.done), 32'h0);
    cyc();
    check("shl_q3", 32'(bus.q), 32'h2F);
    check("shl_sout3", 32'(bus.sout), 32'h1);
    check("shl_busy3", 32'(bus.busy), 32'h0);
    check("shl_done3", 32'(bus.done), 32'h1);
    bus.tick = 1'b0;
    cyc();
    check("shl_done_fall", 32'(bus.done), 32'h0);

    // SHL with amt=0 completes immediately
    issue(3'b001, 4'd0, 8'h00);
    check("shl0_done", 32'(bus.done), 32'h1);
    check("shl0_busy", 32'(bus.busy), 32'h0);
    check("shl0_q", 32'(bus.q), 32'h2F);

    // CLEAR accepted in the done cycle
    issue(3'b111, 4'd0, 8'h00);
    check("clr_q", 32'(bus.q), 32'h00);
    check("clr_done", 32'(bus.done), 32'h1);

    // LOAD then ASR by 2 with a stray start during RUN
    issue(3'b110, 4'd0, 8'h90);
    bus.tick = 1'b1;
    issue(3'b011, 4'd2, 8'h00);
    n_done = 0;
    bus.start = 1'b1;
    bus.mode  = 3'b110;
    bus.data  = 8'h11;
    for (int i = 0; i < 5; i++) begin
      cyc();
      bus.start = 1'b0;
      if (bus.done) n_done++;
    end
    bus.tick = 1'b0;
    check("asr_q", 32'(bus.q), 32'hE4);
    check("asr_sout", 32'(bus.sout), 32'h0);
    check("asr_done_count", 32'(n_done), 32'd1);
    check("asr_busy", 32'(bus.busy), 32'h0);

    // LOAD then ROR by 4 with a tick every 4th cycle
    issue(3'b110, 4'd0, 8'h3C);
    issue(3'b101, 4'd4, 8'h00);
`ifdef USR_ROT_EN
    check("ror_accept_busy", 32'(bus.busy), 32'h1);
    for (int i = 0; i < 16; i++) begin
      bus.tick = (i % 4 == 3);
      cyc();
      if (i < 15) check("ror_busy_held", 32'(bus.busy), 32'h1);
    end
    bus.tick = 1'b0;
    check("ror_q", 32'(bus.q), 32'hC3);
    check("ror_done", 32'(bus.done), 32'h1);
    check("ror_busy_end", 32'(bus.busy), 32'h0);
`else
    check("ror_hold_q", 32'(bus.q), 32'h3C);
    check("ror_hold_done", 32'(bus.done), 32'h1);
    check("ror_hold_busy", 32'(bus.busy), 32'h0);
`endif
    cyc();

    // ROL with amt=9 clipped to 8 steps
    issue(3'b110, 4'd0, 8'h81);
    bus.tick = 1'b1;
    issue(3'b100, 4'd9, 8'h00);
`ifdef USR_ROT_EN
    for (int i = 0; i < 7; i++) cyc();
    check("rol_busy7", 32'(bus.busy), 32'h1);
    check("rol_q7", 32'(bus.q), 32'hC0);
    cyc();
    check("rol_q8", 32'(bus.q), 32'h81);
    check("rol_sout8", 32'(bus.sout), 32'h1);
    check("rol_done8", 32'(bus.done), 32'h1);
    check("rol_busy8", 32'(bus.busy), 32'h0);
`else
    check("rol_hold_q", 32'(bus.q), 32'h81);
    check("rol_hold_done", 32'(bus.done), 32'h1);
    check("rol_hold_busy", 32'(bus.busy), 32'h0);
`endif
    bus.tick = 1'b0;
    cyc();

    // Reset in the middle of SHR
    issue(3'b110, 4'd0, 8'hFF);
    bus.sin  = 1'b0;
    bus.tick = 1'b1;
    issue(3'b010, 4'd5, 8'h00);
    cyc();
    cyc();
    check("shr_q2", 32'(bus.q), 32'h3F);
    check("shr_sout2", 32'(bus.sout), 32'h1);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    bus.tick = 1'b0;
    check("mid_rst_q", 32'(bus.q), 32'h00);
    check("mid_rst_busy", 32'(bus.busy), 32'h0);
    check("mid_rst_done", 32'(bus.done), 32'h0);
    check("mid_rst_sout", 32'(bus.sout), 32'h0);
    cyc();
    check("post_rst_done", 32'(bus.done), 32'h0);
    issue(3'b110, 4'd0, 8'h5A);
    check("post_rst_load_q", 32'(bus.q), 32'h5A);
    check("post_rst_load_done", 32'(bus.done), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
